// File: rtl/geofence_pkg.sv
// Shared types and width helpers for the parametrised geofence block.
package geofence_pkg;

    typedef enum logic [2:0] {
        IDLE, LOAD, SORT_A, SORT_B, SORT_X, TEST_A, TEST_B, DONE
    } state_e;

    function automatic int unsigned diff_w(input int unsigned cw);
        return cw + 1;
    endfunction

    function automatic int unsigned prod_w(input int unsigned cw);
        return 2 * cw + 3;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n_vert);
        return $clog2(n_vert + 1);
    endfunction

endpackage

// File: rtl/geofence_cross.sv
// Two-phase cross product (u1-u0) x (w1-w0) on one shared multiplier.
// The first phase registers ux*wy; the second subtracts wx*uy and flags the sign/zero.
module geofence_cross
    import geofence_pkg::*;
#(
    parameter int unsigned CW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          phase_a,
    input  logic [CW-1:0] u0_x,
    input  logic [CW-1:0] u0_y,
    input  logic [CW-1:0] u1_x,
    input  logic [CW-1:0] u1_y,
    input  logic [CW-1:0] w0_x,
    input  logic [CW-1:0] w0_y,
    input  logic [CW-1:0] w1_x,
    input  logic [CW-1:0] w1_y,
    output logic          neg,
    output logic          zero
);
    localparam int unsigned DW = diff_w(CW);
    localparam int unsigned PW = prod_w(CW);

    logic signed [DW-1:0] ux, uy, wx, wy, op_a, op_b;
    logic signed [PW-1:0] op_a_x, op_b_x, mult, prod_q, res;

    assign ux = $signed({1'b0, u1_x}) - $signed({1'b0, u0_x});
    assign uy = $signed({1'b0, u1_y}) - $signed({1'b0, u0_y});
    assign wx = $signed({1'b0, w1_x}) - $signed({1'b0, w0_x});
    assign wy = $signed({1'b0, w1_y}) - $signed({1'b0, w0_y});

    assign op_a   = phase_a ? ux : wx;
    assign op_b   = phase_a ? wy : uy;
    assign op_a_x = PW'(op_a);
    assign op_b_x = PW'(op_b);
    assign mult   = op_a_x * op_b_x;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
        end else if (phase_a) begin
            prod_q <= mult;
        end
    end

    assign res  = prod_q - mult;
    assign neg  = res[PW-1];
    assign zero = (res == '0);

endmodule

// File: rtl/geofence_poly.sv
// Point-in-convex-polygon test: loads a target plus N_VERT vertices, sorts them
// angularly about vertex 1, then walks the edges. GEOFENCE_ON_EDGE_EN counts boundary as inside.
module geofence_poly
    import geofence_pkg::*;
#(
    parameter int unsigned N_VERT = 6,
    parameter int unsigned CW     = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    output logic          in_ready,
    output logic          valid,
    output logic          is_inside
);
    localparam int unsigned   IW   = idx_w(N_VERT);
    localparam logic [IW-1:0] LAST = IW'(N_VERT);
`ifdef GEOFENCE_ON_EDGE_EN
    localparam bit ON_EDGE = 1'b1;
`else
    localparam bit ON_EDGE = 1'b0;
`endif

    logic [CW-1:0] vx [0:N_VERT];
    logic [CW-1:0] vy [0:N_VERT];
    state_e        state;
    logic [IW-1:0] wr_idx, j, jmax, k, j_nx, k_nx;
    logic          take, sort_ph, phase_a, xc_neg, xc_zero, edge_ok;
    logic [CW-1:0] u0_x, u0_y, u1_x, u1_y, w0_x, w0_y, w1_x, w1_y;

    assign take    = in_valid & in_ready;
    assign j_nx    = j + IW'(1);
    assign k_nx    = (k == LAST) ? IW'(1) : k + IW'(1);
    assign sort_ph = (state == SORT_A) || (state == SORT_B) || (state == SORT_X);
    assign phase_a = (state == SORT_A) || (state == TEST_A);
    assign edge_ok = xc_neg | (ON_EDGE & xc_zero);

    // Sort: (v[j]-v1) x (v[j+1]-v1). Test: (a-t) x (b-a) with a=v[k], b=v[k+1 wrapping].
    always_comb begin
        if (sort_ph) begin
            u0_x = vx[1];    u0_y = vy[1];
            u1_x = vx[j];    u1_y = vy[j];
            w0_x = vx[1];    w0_y = vy[1];
            w1_x = vx[j_nx]; w1_y = vy[j_nx];
        end else begin
            u0_x = vx[0];    u0_y = vy[0];
            u1_x = vx[k];    u1_y = vy[k];
            w0_x = vx[k];    w0_y = vy[k];
            w1_x = vx[k_nx]; w1_y = vy[k_nx];
        end
    end

    geofence_cross #(
        .CW(CW)
    ) u_cross (
        .clk     (clk),
        .reset   (reset),
        .phase_a (phase_a),
        .u0_x    (u0_x),
        .u0_y    (u0_y),
        .u1_x    (u1_x),
        .u1_y    (u1_y),
        .w0_x    (w0_x),
        .w0_y    (w0_y),
        .w1_x    (w1_x),
        .w1_y    (w1_y),
        .neg     (xc_neg),
        .zero    (xc_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_idx    <= '0;
            j         <= '0;
            jmax      <= '0;
            k         <= '0;
            in_ready  <= 1'b0;
            valid     <= 1'b0;
            is_inside <= 1'b0;
            for (int i = 0; i <= int'(N_VERT); i++) begin
                vx[i] <= '0;
                vy[i] <= '0;
            end
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (take) begin
                        vx[0]  <= X;
                        vy[0]  <= Y;
                        wr_idx <= IW'(1);
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (take) begin
                        vx[wr_idx] <= X;
                        vy[wr_idx] <= Y;
                        if (wr_idx == LAST) begin
                            in_ready <= 1'b0;
                            j        <= IW'(2);
                            jmax     <= LAST - IW'(1);
                            k        <= IW'(1);
                            state    <= (N_VERT == 3) ? TEST_A : SORT_A;
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end
                SORT_A: state <= SORT_B;
                SORT_B: begin
                    // C >= 0 means v[j+1] is not clockwise of v[j]; collinear swaps are harmless.
                    if (!xc_neg) begin
                        vx[j]    <= vx[j_nx];
                        vy[j]    <= vy[j_nx];
                        vx[j_nx] <= vx[j];
                        vy[j_nx] <= vy[j];
                    end
                    state <= SORT_X;
                end
                SORT_X: begin
                    if (j == jmax) begin
                        if (jmax == IW'(2)) begin
                            state <= TEST_A;
                        end else begin
                            jmax  <= jmax - IW'(1);
                            j     <= IW'(2);
                            state <= SORT_A;
                        end
                    end else begin
                        j     <= j_nx;
                        state <= SORT_A;
                    end
                end
                TEST_A: state <= TEST_B;
                TEST_B: begin
                    if (!edge_ok) begin
                        is_inside <= 1'b0;
                        valid     <= 1'b1;
                        state     <= DONE;
                    end else if (k == LAST) begin
                        is_inside <= 1'b1;
                        valid     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k     <= k_nx;
                        state <= TEST_A;
                    end
                end
                DONE: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_geofence_poly.sv
// Directed bench for geofence_poly: a 6-vertex/10-bit instance and a 3-vertex/12-bit instance.
module tb_geofence_poly;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv6, iv3;
    logic [9:0]  x6, y6;
    logic [11:0] x3, y3;
    logic        rdy6, vld6, ins6, rdy3, vld3, ins3;

    int n_vec = 0;
    int n_bad = 0;
    int vxs [6];
    int vys [6];

    always #5 clk = ~clk;

    geofence_poly #(
        .N_VERT (6),
        .CW     (10)
    ) dut6 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (iv6),
        .X         (x6),
        .Y         (y6),
        .in_ready  (rdy6),
        .valid     (vld6),
        .is_inside (ins6)
    );

    geofence_poly #(
        .N_VERT (3),
        .CW     (12)
    ) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (iv3),
        .X         (x3),
        .Y         (y3),
        .in_ready  (rdy3),
        .valid     (vld3),
        .is_inside (ins3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample and hold it until the accepting edge; returns #1 after that edge.
    task automatic send(input bit s3, input int x, input int y);
        int t;
        @(negedge clk);
        if (s3) begin
            x3 = 12'(x); y3 = 12'(y); iv3 = 1'b1;
        end else begin
            x6 = 10'(x); y6 = 10'(y); iv6 = 1'b1;
        end
        t = 0;
        while (!(s3 ? rdy3 : rdy6) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!(s3 ? rdy3 : rdy6)) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        iv3 = 1'b0;
        iv6 = 1'b0;
    endtask

    // Cycle index of valid, counting the cycle that accepted the last vertex as 0.
    task automatic wait_result(input bit s3, output int lat, output logic res,
                               output logic rdy_seen);
        lat      = 0;
        res      = 1'bx;
        rdy_seen = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (s3 ? rdy3 : rdy6) rdy_seen = 1'b1;
            if (s3 ? vld3 : vld6) begin
                lat = c;
                res = s3 ? ins3 : ins6;
                break;
            end
        end
    endtask

    task automatic run(input bit s3, input string tag, input int tx, input int ty,
                       input int nv, input int ngaps, input bit exp_in, input int exp_lat);
        int   gap_at [6];
        int   lat;
        logic res, rdy_seen;
        for (int i = 0; i < 6; i++) gap_at[i] = 0;
        for (int g = 0; g < ngaps; g++) gap_at[$urandom_range(0, nv - 1)]++;
        send(s3, tx, ty);
        for (int i = 0; i < nv; i++) begin
            repeat (gap_at[i]) @(negedge clk);
            send(s3, vxs[i], vys[i]);
        end
        wait_result(s3, lat, res, rdy_seen);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_inside"}, {31'd0, res}, {31'd0, exp_in});
        check({tag, "_ready_low_while_busy"}, {31'd0, rdy_seen}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid_one_cycle"}, {31'd0, s3 ? vld3 : vld6}, 32'd0);
        check({tag, "_ready_back_in_idle"}, {31'd0, s3 ? rdy3 : rdy6}, 32'd1);
        check({tag, "_inside_held"}, {31'd0, s3 ? ins3 : ins6}, {31'd0, exp_in});
    endtask

    initial begin
        logic vld_seen;
        reset = 1'b1;
        iv6 = 1'b0; iv3 = 1'b0;
        x6 = '0; y6 = '0; x3 = '0; y3 = '0;
        #12;
        check("reset_in_ready", {31'd0, rdy6}, 32'd0);
        check("reset_valid", {31'd0, vld6}, 32'd0);
        check("reset_is_inside", {31'd0, ins6}, 32'd0);
        check("reset_in_ready_n3", {31'd0, rdy3}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Shuffled hexagon; sorted clockwise it is (150,100),(125,57),(75,57),(50,100),(75,143),(125,143).
        vxs = '{150, 75, 125, 50, 125, 75};
        vys = '{100, 57, 143, 100, 57, 143};

        // All six edges give E<0: 30 sort + 12 test + 1 done.
        run(1'b0, "hex_inside", 100, 100, 6, 0, 1'b1, 43);
        // First edge (150,100)->(125,57) gives E=+2150: 30 sort + 2 test + 1 done.
        run(1'b0, "hex_outside", 200, 100, 6, 0, 1'b0, 33);
        // Top edge (75,143)->(125,143) is edge 5 with E=0; all other edges are negative.
`ifdef GEOFENCE_ON_EDGE_EN
        run(1'b0, "hex_on_edge", 100, 143, 6, 0, 1'b1, 43);
`else
        run(1'b0, "hex_on_edge", 100, 143, 6, 0, 1'b0, 41);
`endif
        run(1'b0, "gap_outside", 200, 100, 6, 3, 1'b0, 33);
        run(1'b0, "gap_inside", 100, 100, 6, 3, 1'b1, 43);

        // Abort mid-sort: cycle 1 after the last vertex is SORT_A, cycle 2 is SORT_B.
        send(1'b0, 100, 100);
        for (int i = 0; i < 6; i++) send(1'b0, vxs[i], vys[i]);
        @(posedge clk);
        #2;
        check("abort_prior_inside", {31'd0, ins6}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_valid", {31'd0, vld6}, 32'd0);
        check("abort_is_inside", {31'd0, ins6}, 32'd0);
        check("abort_in_ready", {31'd0, rdy6}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        vld_seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (vld6) vld_seen = 1'b1;
        end
        check("abort_no_valid", {31'd0, vld_seen}, 32'd0);
        run(1'b0, "after_abort", 100, 100, 6, 0, 1'b1, 43);

        // Triangle sent clockwise (no sort for three vertices); E = -4e6, -8e6, -4e6.
        vxs = '{0, 0, 4000, 0, 0, 0};
        vys = '{0, 4000, 0, 0, 0, 0};
        run(1'b1, "tri_inside", 1000, 1000, 3, 0, 1'b1, 7);
        // Same triangle, target past the hypotenuse: edge 2 gives E=+800000 -> 2*2+1.
        run(1'b1, "tri_outside", 2100, 2100, 3, 0, 1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/geofence_poly.md
Name: geofence_poly

Overview:
Parametrised successor of the 6-vertex geofence block. It accepts one target point and N_VERT unordered fence vertices, sorts the vertices angularly about the first vertex using cross-product bubble sort, and reports whether the target lies strictly inside the convex fence. It adds several things the fixed version lacks: configurable vertex count and coordinate width, an input valid/ready handshake, early exit on the first outside edge, and a compile-time boundary mode.

Parameters:
N_VERT, 6, number of fence vertices; legal range 3..15.
CW, 10, unsigned coordinate width in bits.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  X/Y carry a sample this cycle
X  in  CW  x coordinate, unsigned
Y  in  CW  y coordinate, unsigned
in_ready  out  1  block accepts a sample this cycle
valid  out  1  one-cycle pulse; is_inside is valid in this cycle
is_inside  out  1  result of the current set

Behaviour:
- Reset (asynchronous, active-high; polarity and synchronicity fixed): state=IDLE, count registers=0, in_ready=0, valid=0, is_inside=0, buffers=0. Reset mid-operation aborts the set, and no valid is issued for it.
- Buffer: entry 0 holds the target; entries 1..N_VERT hold vertices in arrival order. Entry 1 is the sort root.
- Sample acceptance: a sample is taken when in_valid&in_ready. in_ready=1 only in IDLE and LOAD.
- IDLE: on the first accepted sample, write entry 0 and go to LOAD.
- LOAD: write the next entry on each accepted sample. After entry N_VERT is written, go to SORT_A. Cycles without in_valid leave the state unchanged.
- Cross arithmetic: one shared multiplier. Differences are signed CW+1 bits; products and results are signed 2*CW+3 bits, so there is no overflow.
- Sort: C = cross(v[j]-v1, v[j+1]-v1) = (xj-x1)(yj+1-y1) - (xj+1-x1)(yj-y1).
  - SORT_A computes and stores the first product.
  - SORT_B computes C. If C >= 0, swap v[j] and v[j+1] at the end of SORT_B.
  - SORT_X advances j.
  - Passes p = 0..N_VERT-3. Pass p covers j = 2..N_VERT-1-p. The sort is skipped entirely when N_VERT=3 (go straight to TEST_A).
- Test: for edge k, with a=v[k] and b=v[k mod N_VERT +1], E = (ax-tx)(by-ay) - (bx-ax)(ay-ty).
  - TEST_A stores the first product; TEST_B evaluates E.
  - The edge passes if E<0.
  - If the edge fails, clear the result and go to DONE immediately (early exit).
  - If the edge passes and k=N_VERT, go to DONE; otherwise k++ and return to TEST_A.
- DONE: valid=1 and is_inside=registered result for exactly one cycle, then IDLE.
- is_inside holds its value until the next DONE or reset.
- Latency from the last vertex accepted to valid, without early exit: 3*(N_VERT-1)(N_VERT-2)/2 + 2*N_VERT + 1 cycles. For N_VERT=6 this is 43.
- Degenerate inputs:
  - Coincident or collinear vertices produce C=0 and are swapped; this is harmless.
  - A target equal to a vertex gives E=0 and is reported outside unless the optional feature is enabled.

Optional Feature:
GEOFENCE_ON_EDGE_EN
- Defined: an edge passes if E <= 0, so targets on the boundary or at a vertex are reported inside.
- Undefined: strict test (E < 0), so boundary targets are reported outside.
- No other timing or port difference.

Decomposition:
- Shared package geofence_pkg:
  - State enum: IDLE, LOAD, SORT_A, SORT_B, SORT_X, TEST_A, TEST_B, DONE.
  - Width functions: diff width CW+1, product width 2*CW+3.
  - Index width constant: clog2(N_VERT+1).
- Sub-module geofence_cross: registered two-phase cross-product unit.
  - Holds the operand muxes, subtractors, multiplier and product register.
  - Outputs the sign and zero flag of the result.
  - Is reused by both the sort and test phases.

Test Plan:
- N_VERT=6, CW=10. Target (100,100); vertices sent shuffled: (150,100),(75,57),(125,143),(50,100),(125,57),(75,143). Required: valid after 43 cycles, is_inside=1.
- Same vertices, target (200,100). Required: is_inside=0, and valid arrives earlier than 43 cycles (early exit).
- Target (100,143), on the top edge. Required: is_inside=0 without GEOFENCE_ON_EDGE_EN and 1 with it.
- in_valid deasserted for 3 random cycles during LOAD. Required: same results as above, latency counted from the last vertex accepted, and in_ready=0 from SORT_A until the next IDLE.
- Reset asserted during SORT_B of a set. Required: outputs clear immediately, no valid pulse for that set, and a fresh set afterwards gives the correct result.
- N_VERT=3, CW=12. Triangle (0,0),(4000,0),(0,4000) with target (1000,1000). Required: is_inside=1, valid 7 cycles after the last vertex; corner coordinates cause no overflow.
